// File: rtl/actuador_puertas.sv
// Door mechanism stage: follows the door controller's salida_puertas command,
// drives the motor, tracks door position and reports status plus open-hold timeout.
// Optional feature: define SENSOR_REVERSA_EN to make the obstruction sensor force a
// reversal while closing and raise obstruido after repeated reversals.
//
// state    | meaning
// CERRADA  | 00 doors fully closed, posicion = 0
// ABIERTA  | 01 doors fully open, hold counter running
// CERRANDO | 10 closing, advances on cmd 10
// ABRIENDO | 11 opening, advances on cmd 01
module actuador_puertas #(
    parameter int T_MOVIMIENTO = 8,
    parameter int T_ESPERA     = 20,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       salida_puertas,
    input  logic             sensor,
    output logic [1:0]       puertas,
    output logic             timeout,
    output logic [1:0]       motor,
    output logic [CNT_W-1:0] posicion,
    output logic             obstruido
);

    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        CERRANDO = 2'b10,
        ABRIENDO = 2'b11
    } estado_t;

    localparam logic [1:0] CMD_ABRIR  = 2'b01;
    localparam logic [1:0] CMD_CERRAR = 2'b10;

    localparam logic [CNT_W-1:0] T_MOV_C = CNT_W'(T_MOVIMIENTO);
    localparam logic [CNT_W-1:0] T_ESP_C = CNT_W'(T_ESPERA);
    localparam logic [CNT_W-1:0] UNO_C   = CNT_W'(1);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] hold_q, hold_d;

`ifdef SENSOR_REVERSA_EN
    logic [2:0] rev_q, rev_d;
`endif

    // State, position and hold counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CERRADA;
            pos_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hold_q  <= hold_d;
        end
    end

`ifdef SENSOR_REVERSA_EN
    // Forced-reversal counter, saturating at 7
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rev_q <= '0;
        end else begin
            rev_q <= rev_d;
        end
    end
`endif

    // Next-state, position and hold update; illegal cmd 11 behaves as 00
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
`ifdef SENSOR_REVERSA_EN
        rev_d   = rev_q;
`endif
        unique case (state_q)
            CERRADA: begin
                if (salida_puertas == CMD_ABRIR) begin
                    state_d = ABRIENDO;
                end
            end
            ABRIENDO: begin
                if (salida_puertas == CMD_ABRIR) begin
                    // >= also covers a reversal that happened at full travel
                    if (pos_q >= T_MOV_C - UNO_C) begin
                        pos_d   = T_MOV_C;
                        state_d = ABIERTA;
                        hold_d  = '0;
                    end else begin
                        pos_d = pos_q + UNO_C;
                    end
                end else if (salida_puertas == CMD_CERRAR) begin
                    state_d = CERRANDO;
                end
            end
            ABIERTA: begin
                if (salida_puertas == CMD_ABRIR) begin
                    hold_d = '0;
                end else if (salida_puertas == CMD_CERRAR) begin
                    state_d = CERRANDO;
                    hold_d  = '0;
                end else if (hold_q < T_ESP_C) begin
                    hold_d = hold_q + UNO_C;
                end
            end
            CERRANDO: begin
`ifdef SENSOR_REVERSA_EN
                if (sensor) begin
                    state_d = ABRIENDO;
                    if (rev_q != 3'd7) begin
                        rev_d = rev_q + 3'd1;
                    end
                end else
`endif
                if (salida_puertas == CMD_CERRAR) begin
                    // <= also covers a reversal that happened at position 0
                    if (pos_q <= UNO_C) begin
                        pos_d   = '0;
                        state_d = CERRADA;
                    end else begin
                        pos_d = pos_q - UNO_C;
                    end
                end else if (salida_puertas == CMD_ABRIR) begin
                    state_d = ABRIENDO;
                end
            end
            default: state_d = CERRADA;
        endcase
`ifdef SENSOR_REVERSA_EN
        if (state_d == CERRADA) begin
            rev_d = '0;
        end
`endif
    end

    // Motor decode from registered state and live command
    always_comb begin
        motor = 2'b00;
        if (state_q == ABRIENDO && salida_puertas == CMD_ABRIR) begin
            motor = 2'b01;
        end else if (state_q == CERRANDO && salida_puertas == CMD_CERRAR) begin
            motor = 2'b10;
        end
    end

    assign puertas  = state_q;
    assign posicion = pos_q;
    assign timeout  = (state_q == ABIERTA) && (hold_q == T_ESP_C);

`ifdef SENSOR_REVERSA_EN
    assign obstruido = (rev_q >= 3'd4);
`else
    logic sensor_unused;
    assign sensor_unused = sensor;
    assign obstruido     = 1'b0;
`endif

endmodule

// File: tb/tb_actuador_puertas.sv
// Scoreboard bench for actuador_puertas: stimulus pushes the outputs expected in
// each cycle window, a negedge monitor pops and compares.
module tb_actuador_puertas;

    logic       clk;
    logic       rst_n;
    logic [1:0] salida_puertas;
    logic       sensor;
    logic [1:0] puertas;
    logic       timeout;
    logic [1:0] motor;
    logic [7:0] posicion;
    logic       obstruido;

    actuador_puertas #(
        .T_MOVIMIENTO(8),
        .T_ESPERA    (20),
        .CNT_W       (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .salida_puertas(salida_puertas),
        .sensor        (sensor),
        .puertas       (puertas),
        .timeout       (timeout),
        .motor         (motor),
        .posicion      (posicion),
        .obstruido     (obstruido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [1:0] p;
        logic [1:0] m;
        logic [7:0] pos;
        logic       to;
        logic       ob;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: one expected entry per cycle window, sampled at negedge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (puertas !== e.p || motor !== e.m || posicion !== e.pos ||
                timeout !== e.to || obstruido !== e.ob) begin
                n_err++;
                $display("FAIL %s: got puertas=%b motor=%b pos=%0d to=%b ob=%b, want puertas=%b motor=%b pos=%0d to=%b ob=%b",
                         e.nm, puertas, motor, posicion, timeout, obstruido,
                         e.p, e.m, e.pos, e.to, e.ob);
            end
        end
    end

    // Drive one cycle of inputs just after a posedge and queue the expected window
    task automatic vec(input string nm, input logic rb, input logic [1:0] cmd,
                       input logic s, input logic [1:0] ep, input logic [1:0] em,
                       input int epos, input logic eto, input logic eob);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n          = rb;
        salida_puertas = cmd;
        sensor         = s;
        e.nm  = nm;
        e.p   = ep;
        e.m   = em;
        e.pos = 8'(epos);
        e.to  = eto;
        e.ob  = eob;
        sb.push_back(e);
    endtask

    // From CERRADA: one edge to ABRIENDO, eight advancing edges to ABIERTA
    task automatic abrir_completo(input string nm);
        vec({nm, "_start"}, 1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            vec({nm, "_opening"}, 1, 2'b01, 0, 2'b11, 2'b01, i, 0, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        salida_puertas = 2'b00;
        sensor         = 1'b0;

        // Reset state
        vec("reset0", 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
        vec("reset1", 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);

        // Opening from reset, cmd 01 held
        abrir_completo("t1");
        vec("t1_open", 1, 2'b00, 0, 2'b01, 2'b00, 8, 0, 0);

        // Hold timeout: entered ABIERTA, one cmd-00 edge already counted above
        for (int k = 1; k < 20; k++)
            vec("t2_hold", 1, 2'b00, 0, 2'b01, 2'b00, 8, 0, 0);
        vec("t2_timeout", 1, 2'b00, 0, 2'b01, 2'b00, 8, 1, 0);
        vec("t2_sat", 1, 2'b11, 0, 2'b01, 2'b00, 8, 1, 0);
        vec("t2_clear_cmd", 1, 2'b01, 0, 2'b01, 2'b00, 8, 1, 0);
        for (int k = 0; k < 20; k++)
            vec("t2_hold2", 1, 2'b00, 0, 2'b01, 2'b00, 8, 0, 0);
        vec("t2_timeout2", 1, 2'b10, 0, 2'b01, 2'b00, 8, 1, 0);

        // Closing, then reversal at posicion 3
        for (int p = 8; p >= 4; p--)
            vec("t3_closing", 1, 2'b10, 0, 2'b10, 2'b10, p, 0, 0);
        vec("t3_rev_cmd", 1, 2'b01, 0, 2'b10, 2'b00, 3, 0, 0);
        vec("t3_reversed", 1, 2'b01, 0, 2'b11, 2'b01, 3, 0, 0);
        vec("t3_rise", 1, 2'b01, 0, 2'b11, 2'b01, 4, 0, 0);

        // Pause mid-opening at 5 with 00 and 11
        vec("t4_pause00", 1, 2'b00, 0, 2'b11, 2'b00, 5, 0, 0);
        vec("t4_pause11", 1, 2'b11, 0, 2'b11, 2'b00, 5, 0, 0);
        vec("t4_pause00b", 1, 2'b00, 0, 2'b11, 2'b00, 5, 0, 0);
        vec("t4_resume", 1, 2'b01, 0, 2'b11, 2'b01, 5, 0, 0);
        // Asynchronous reset at posicion 6
        vec("t4_rst_mid", 0, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
        vec("t4_after_rst", 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);

        // Full close down to CERRADA
        abrir_completo("t3b");
        vec("t3b_open", 1, 2'b10, 0, 2'b01, 2'b00, 8, 0, 0);
        for (int p = 8; p >= 1; p--)
            vec("t3b_closing", 1, 2'b10, 0, 2'b10, 2'b10, p, 0, 0);
        vec("t3b_closed", 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);

        // Reversal at position 0 must not wrap
        vec("b0_start", 1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0);
        vec("b0_to_close", 1, 2'b10, 0, 2'b11, 2'b00, 0, 0, 0);
        vec("b0_close0", 1, 2'b10, 0, 2'b10, 2'b10, 0, 0, 0);
        vec("b0_closed", 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);

        // Sensor during closing
        abrir_completo("t5");
        vec("t5_open", 1, 2'b10, 0, 2'b01, 2'b00, 8, 0, 0);
`ifdef SENSOR_REVERSA_EN
        for (int r = 0; r < 4; r++) begin
            vec("t5_sensor", 1, 2'b10, 1, 2'b10, 2'b10, 8, 0, 0);
            vec("t5_reopening", 1, 2'b10, 0, 2'b11, 2'b00, 8, 0, (r + 1 >= 4));
        end
        for (int p = 8; p >= 1; p--)
            vec("t5_closing_ob", 1, 2'b10, 0, 2'b10, 2'b10, p, 0, 1);
        vec("t5_closed", 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
`else
        for (int r = 0; r < 4; r++) begin
            vec("t5_sensor_ign", 1, 2'b10, 1, 2'b10, 2'b10, 8 - 2 * r, 0, 0);
            vec("t5_closing", 1, 2'b10, 0, 2'b10, 2'b10, 7 - 2 * r, 0, 0);
        end
        vec("t5_closed", 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
`endif

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
